// File: rtl/systolic_input_skewer_pkg.sv
// Shared definitions for the systolic input skewer: default sizing, FSM states, lane slicing.
// Pure declarations, no logic; imported by the interface, the skewer and its lane sub-module.
package systolic_input_skewer_pkg;

  localparam int ARRAY_SIZE_DEF = 9;
  localparam int DATA_SIZE_DEF  = 16;
  localparam int FIFO_DEPTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Lane i occupies bits [(i+1)*data_size-1 : i*data_size] of a packed row vector.
  function automatic int lane_lo(input int lane, input int data_size);
    return lane * data_size;
  endfunction

endpackage

// File: rtl/systolic_input_skewer_if.sv
// Row-vector input handshake plus skewed output bus of the systolic input skewer.
// master = activation source / observer side, slave = skewer side.
interface systolic_input_skewer_if
  import systolic_input_skewer_pkg::*;
#(
  parameter int array_size = ARRAY_SIZE_DEF,
  parameter int data_size  = DATA_SIZE_DEF
);
  logic [array_size*data_size-1:0] in_data;
  logic                            in_valid;
  logic                            in_last;
  logic                            in_ready;
  logic [array_size*data_size-1:0] out_data;
  logic [array_size-1:0]           lane_valid;
  logic                            tile_start;
  logic                            tile_done;
  logic                            busy;
  logic                            err_overflow;

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, out_data, lane_valid, tile_start, tile_done, busy, err_overflow
  );

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, out_data, lane_valid, tile_start, tile_done, busy, err_overflow
  );
endinterface

// File: rtl/systolic_input_skewer_skew_lane.sv
// Per-lane delay line: depth-stage shift register, wire-through when depth is 0.
// Latency: depth cycles; no backpressure, shifts every cycle.
module systolic_input_skewer_skew_lane #(
  parameter int depth = 1,
  parameter int width = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);
  if (depth == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign q = d;
  end else begin : g_shift
    logic [width-1:0] sr [depth];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < depth; k++) sr[k] <= '0;
      end else begin
        sr[0] <= d;
        for (int k = 1; k < depth; k++) sr[k] <= sr[k-1];
      end
    end

    assign q = sr[depth-1];
  end
endmodule

// File: rtl/systolic_input_skewer.sv
// Buffers complete tiles of row vectors and replays each as one burst with lane i delayed i cycles.
// Latency: lane i = pop + 1 + i cycles; backpressure: in_ready low while the FIFO is full.
module systolic_input_skewer
  import systolic_input_skewer_pkg::*;
#(
  parameter int array_size = ARRAY_SIZE_DEF,
  parameter int data_size  = DATA_SIZE_DEF,
  parameter int fifo_depth = FIFO_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  systolic_input_skewer_if.slave  bus
);
  localparam int aw = $clog2(fifo_depth);
  localparam int cw = (array_size > 2) ? $clog2(array_size) : 1;
  localparam int lw = array_size * data_size;
  localparam logic [aw:0]   full_cnt   = (aw+1)'(fifo_depth);
  localparam logic [cw-1:0] flush_last = cw'(array_size - 2);

  logic [lw:0]   mem [fifo_depth];
  logic [aw-1:0] wptr_q, rptr_q;
  logic [aw:0]   count_q, pend_q;
  logic          err_q;
  logic [lw:0]   head;
  logic          in_ready_w, push, pop, head_last;

  state_t        state_q, state_d;
  logic [cw-1:0] flush_cnt_q, flush_cnt_d;
  logic          started_q, started_d;
  logic          tile_start_w, tile_done_w;

  logic [lw-1:0] s0_dat;
  logic          s0_vld;
  logic [lw-1:0]         out_w;
  logic [array_size-1:0] lane_vld_w;

  assign in_ready_w = (count_q != full_cnt);
  assign push       = bus.in_valid && in_ready_w;
  assign head       = mem[rptr_q];
  assign head_last  = head[lw];

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= {bus.in_last, bus.in_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
      case ({push && bus.in_last, pop && head_last})
        2'b10:   pend_q <= pend_q + 1'b1;
        2'b01:   pend_q <= pend_q - 1'b1;
        default: ;
      endcase
      // A full FIFO without a complete tile can never drain: flag it and stay stuck.
      if (count_q == full_cnt && pend_q == '0) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      started_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      started_q   <= started_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    started_d    = started_q;
    pop          = 1'b0;
    tile_start_w = 1'b0;
    tile_done_w  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        started_d = 1'b0;
        if (pend_q != '0) state_d = ST_FEED;
      end
      ST_FEED: begin
        pop          = 1'b1;
        tile_start_w = !started_q;
        started_d    = 1'b1;
        if (head_last) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == flush_last) begin
          tile_done_w = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Common output stage: zeros are injected whenever nothing is popped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_dat <= '0;
      s0_vld <= 1'b0;
    end else begin
      s0_dat <= pop ? head[lw-1:0] : '0;
      s0_vld <= pop;
    end
  end

  for (genvar i = 0; i < array_size; i++) begin : g_lane
    logic [data_size:0] lane_q;
    systolic_input_skewer_skew_lane #(.depth(i), .width(data_size + 1)) u_lane (
      .clk   (clk),
      .reset (reset),
      .d     ({s0_vld, s0_dat[lane_lo(i, data_size) +: data_size]}),
      .q     (lane_q)
    );
    assign out_w[lane_lo(i, data_size) +: data_size] = lane_q[data_size-1:0];
    assign lane_vld_w[i] = lane_q[data_size];
  end

  assign bus.in_ready     = in_ready_w;
  assign bus.out_data     = out_w;
  assign bus.lane_valid   = lane_vld_w;
  assign bus.tile_start   = tile_start_w;
  assign bus.tile_done    = tile_done_w;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.err_overflow = err_q;
endmodule
